guess_game_ctrl: RTL and testbench

GUESS_GAME_CTRL -- requirements
Module: guess_game_ctrl

---
 rtl/guess_game_ctrl_if.sv | 35 +++
 rtl/guess_game_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_guess_game_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/guess_game_ctrl_if.sv
// guess_game_ctrl_if -- keypad/display/score bundle for the guess game controller.
// The master side (keypad and display host) drives the key strobes and new_game;
// the slave side (guess_game_ctrl) drives the accepted number, score and status.
interface guess_game_ctrl_if;
    logic [3:0] key_val;
    logic       key_vld;
    logic       key_enter;
    logic       key_clear;
    logic       new_game;

    logic [3:0] oNum1;
    logic [3:0] oNum2;
    logic [3:0] oNum3;
    logic       oNumRdy;
    logic [1:0] a_cnt;
    logic [1:0] b_cnt;
    logic       res_vld;
    logic [3:0] attempts;
    logic [2:0] state_o;
    logic       win;
    logic       lose;
    logic       err;

    modport master (
        output key_val, key_vld, key_enter, key_clear, new_game,
        input  oNum1, oNum2, oNum3, oNumRdy, a_cnt, b_cnt, res_vld,
        input  attempts, state_o, win, lose, err
    );

    modport slave (
        input  key_val, key_vld, key_enter, key_clear, new_game,
        output oNum1, oNum2, oNum3, oNumRdy, a_cnt, b_cnt, res_vld,
        output attempts, state_o, win, lose, err
    );
endinterface

// File: rtl/guess_game_ctrl.sv
// guess_game_ctrl -- "bulls and cows" style 3-digit guessing game controller.
// A secret is typed in first, then guesses are scored as A (right digit, right
// place) and B (right digit, wrong place). Digits in any submission are distinct.
// Optional feature: define GAME_ATTEMPT_LIMIT_EN to lose the game after the 8th
// non-winning guess; without it guessing is unlimited and lose stays 0.
module guess_game_ctrl (
    input  logic             clk,
    input  logic             reset,
    guess_game_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SECRET = 3'd1,
        S_GUESS  = 3'd2,
        S_CHECK  = 3'd3,
        S_WIN    = 3'd4,
        S_LOSE   = 3'd5
    } state_t;

`ifdef GAME_ATTEMPT_LIMIT_EN
    localparam logic [3:0] ATTEMPT_LIMIT = 4'd8;
`endif

    state_t          state_q, state_d;
    logic [2:0][3:0] buf_q, buf_d;       // entry buffer, element 0 is the first digit typed
    logic [1:0]      cnt_q, cnt_d;       // digits currently buffered (0..3)
    logic [2:0][3:0] num_q, num_d;       // last accepted number, element 0 drives oNum1
    logic [2:0][3:0] secret_q, secret_d;
    logic [1:0]      a_q, a_d;
    logic [1:0]      b_q, b_d;
    logic [3:0]      att_q, att_d;
    logic            rdy_q, rdy_d;
    logic            res_vld_q, res_vld_d;
    logic            err_q, err_d;

    logic            entry_ok;
    logic            restart;
    logic [1:0]      score_a_c;
    logic [1:0]      score_b_c;
    logic [3:0]      att_inc;
    logic            limit_hit;

    // Position matches between a guess and the secret.
    function automatic logic [1:0] score_a(input logic [2:0][3:0] g, input logic [2:0][3:0] s);
        logic [1:0] n;
        n = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (g[i] == s[i]) n = n + 2'd1;
        end
        return n;
    endfunction

    // Digits of the guess found in the secret at a different position.
    function automatic logic [1:0] score_b(input logic [2:0][3:0] g, input logic [2:0][3:0] s);
        logic [1:0] n;
        n = 2'd0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if ((i != j) && (g[i] == s[j])) n = n + 2'd1;
            end
        end
        return n;
    endfunction

    // Next-state, buffer, score and strobe logic; strobe priority is
    // new_game > key_clear > key_enter > key_vld, losers are dropped.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        secret_d  = secret_q;
        a_d       = a_q;
        b_d       = b_q;
        att_d     = att_q;
        rdy_d     = 1'b0;
        res_vld_d = 1'b0;
        err_d     = 1'b0;

        entry_ok  = (cnt_q == 2'd3) && (buf_q[0] != buf_q[1]) &&
                    (buf_q[0] != buf_q[2]) && (buf_q[1] != buf_q[2]);
        restart   = bus.new_game && (state_q != S_IDLE);
        // The guess being scored is the number latched when CHECK was entered.
        score_a_c = score_a(num_q, secret_q);
        score_b_c = score_b(num_q, secret_q);
        att_inc   = (att_q == 4'd15) ? 4'd15 : att_q + 4'd1;
`ifdef GAME_ATTEMPT_LIMIT_EN
        limit_hit = (att_inc == ATTEMPT_LIMIT);
`else
        limit_hit = 1'b0;
`endif

        if (restart) begin
            state_d = S_SECRET;
            buf_d   = '0;
            cnt_d   = 2'd0;
            att_d   = 4'd0;
            a_d     = 2'd0;
            b_d     = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_SECRET;
                S_SECRET, S_GUESS: begin
                    if (bus.key_clear) begin
                        buf_d = '0;
                        cnt_d = 2'd0;
                    end else if (bus.key_enter) begin
                        if (entry_ok) begin
                            num_d = buf_q;
                            rdy_d = 1'b1;
                            buf_d = '0;
                            cnt_d = 2'd0;
                            if (state_q == S_SECRET) begin
                                secret_d = buf_q;
                                state_d  = S_GUESS;
                            end else begin
                                state_d  = S_CHECK;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (bus.key_vld && (bus.key_val <= 4'd9) && (cnt_q != 2'd3)) begin
                        buf_d[cnt_q] = bus.key_val;
                        cnt_d        = cnt_q + 2'd1;
                    end
                end
                S_CHECK: begin
                    a_d       = score_a_c;
                    b_d       = score_b_c;
                    res_vld_d = 1'b1;
                    att_d     = att_inc;
                    if (score_a_c == 2'd3)  state_d = S_WIN;
                    else if (limit_hit)     state_d = S_LOSE;
                    else                    state_d = S_GUESS;
                end
                S_WIN, S_LOSE: state_d = state_q;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, buffer and output registers; reset returns everything to IDLE/zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            buf_q     <= '0;
            cnt_q     <= 2'd0;
            num_q     <= '0;
            secret_q  <= '0;
            a_q       <= 2'd0;
            b_q       <= 2'd0;
            att_q     <= 4'd0;
            rdy_q     <= 1'b0;
            res_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            secret_q  <= secret_d;
            a_q       <= a_d;
            b_q       <= b_d;
            att_q     <= att_d;
            rdy_q     <= rdy_d;
            res_vld_q <= res_vld_d;
            err_q     <= err_d;
        end
    end

    assign bus.oNum1    = num_q[0];
    assign bus.oNum2    = num_q[1];
    assign bus.oNum3    = num_q[2];
    assign bus.oNumRdy  = rdy_q;
    assign bus.a_cnt    = a_q;
    assign bus.b_cnt    = b_q;
    assign bus.res_vld  = res_vld_q;
    assign bus.attempts = att_q;
    assign bus.state_o  = state_q;
    assign bus.err      = err_q;
    assign bus.win      = (state_q == S_WIN);
`ifdef GAME_ATTEMPT_LIMIT_EN
    assign bus.lose     = (state_q == S_LOSE);
`else
    assign bus.lose     = 1'b0;
`endif
endmodule

// File: tb/tb_guess_game_ctrl.sv
// tb_guess_game_ctrl -- scenario bench for guess_game_ctrl with a scoreboard of
// expected accepted numbers and expected scores.
module tb_guess_game_ctrl;
    logic clk;
    logic reset;
    guess_game_ctrl_if bus ();

    guess_game_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef GAME_ATTEMPT_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    int rdy_seen = 0;
    int res_seen = 0;
    int err_seen = 0;

    logic [11:0] num_q [$];   // expected {oNum1,oNum2,oNum3}
    logic [7:0]  res_q [$];   // expected {a_cnt,b_cnt,attempts}
    logic [3:0]  model_att;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.oNumRdy === 1'b1) rdy_seen++;
        if (bus.res_vld === 1'b1) res_seen++;
        if (bus.err === 1'b1)     err_seen++;
    end

    initial begin
        #2000000;
        $display("FAIL timeout sim_time reached without finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_digit(input logic [3:0] d);
        bus.key_val = d;
        bus.key_vld = 1'b1;
        tick();
        bus.key_vld = 1'b0;
        bus.key_val = 4'd0;
    endtask

    task automatic press_digits(input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3);
        press_digit(d1);
        press_digit(d2);
        press_digit(d3);
    endtask

    task automatic press_enter();
        bus.key_enter = 1'b1;
        tick();
        bus.key_enter = 1'b0;
    endtask

    task automatic press_clear();
        bus.key_clear = 1'b1;
        tick();
        bus.key_clear = 1'b0;
    endtask

    task automatic press_new_game();
        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        model_att = 4'd0;
    endtask

    // Submit a secret; oNumRdy must follow one cycle after enter with the digits.
    task automatic submit_secret(input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3);
        logic [11:0] exp;
        press_digits(d1, d2, d3);
        num_q.push_back({d1, d2, d3});
        press_enter();
        checks++;
        if (bus.oNumRdy !== 1'b1) begin
            failures++;
            $display("FAIL secret_rdy oNumRdy=%b required=1", bus.oNumRdy);
        end else begin
            exp = num_q.pop_front();
            checks++;
            if ({bus.oNum1, bus.oNum2, bus.oNum3} !== exp) begin
                failures++;
                $display("FAIL secret_num oNum=%h required=%h", {bus.oNum1, bus.oNum2, bus.oNum3}, exp);
            end
        end
        checks++;
        if (bus.state_o !== 3'd2) begin
            failures++;
            $display("FAIL secret_state state_o=%0d required=2", bus.state_o);
        end
        tick();
        checks++;
        if (bus.res_vld !== 1'b0 || bus.oNumRdy !== 1'b0) begin
            failures++;
            $display("FAIL secret_no_score res_vld=%b oNumRdy=%b required=0,0", bus.res_vld, bus.oNumRdy);
        end
    endtask

    // Enter the buffered guess and check the number, CHECK occupancy and score.
    task automatic submit_buffer(input logic [11:0] num, input logic [1:0] ea, input logic [1:0] eb);
        logic [11:0] exp_n;
        logic [7:0]  exp_r;
        logic [2:0]  exp_st;
        num_q.push_back(num);
        model_att = (model_att == 4'd15) ? 4'd15 : model_att + 4'd1;
        res_q.push_back({ea, eb, model_att});
        if (ea == 2'd3)                          exp_st = 3'd4;
        else if (LIMIT_EN && model_att == 4'd8)  exp_st = 3'd5;
        else                                     exp_st = 3'd2;
        press_enter();
        checks++;
        if (bus.oNumRdy !== 1'b1 || bus.state_o !== 3'd3) begin
            failures++;
            $display("FAIL guess_accept oNumRdy=%b state_o=%0d required=1,3", bus.oNumRdy, bus.state_o);
        end else begin
            exp_n = num_q.pop_front();
            checks++;
            if ({bus.oNum1, bus.oNum2, bus.oNum3} !== exp_n) begin
                failures++;
                $display("FAIL guess_num oNum=%h required=%h", {bus.oNum1, bus.oNum2, bus.oNum3}, exp_n);
            end
        end
        tick();
        checks++;
        if (bus.res_vld !== 1'b1) begin
            failures++;
            $display("FAIL guess_res_vld res_vld=%b required=1", bus.res_vld);
        end else begin
            exp_r = res_q.pop_front();
            checks++;
            if ({bus.a_cnt, bus.b_cnt, bus.attempts} !== exp_r) begin
                failures++;
                $display("FAIL guess_score a=%0d b=%0d att=%0d required a=%0d b=%0d att=%0d",
                         bus.a_cnt, bus.b_cnt, bus.attempts, exp_r[7:6], exp_r[5:4], exp_r[3:0]);
            end
        end
        checks++;
        if (bus.state_o !== exp_st) begin
            failures++;
            $display("FAIL guess_next_state state_o=%0d required=%0d", bus.state_o, exp_st);
        end
    endtask

    task automatic submit_guess(input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3,
                                input logic [1:0] ea, input logic [1:0] eb);
        press_digits(d1, d2, d3);
        submit_buffer({d1, d2, d3}, ea, eb);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.state_o !== 3'd0) begin
            failures++;
            $display("FAIL reset_state state_o=%0d required=0", bus.state_o);
        end
        checks++;
        if ({bus.oNum1, bus.oNum2, bus.oNum3} !== 12'h000) begin
            failures++;
            $display("FAIL reset_num oNum=%h required=000", {bus.oNum1, bus.oNum2, bus.oNum3});
        end
        checks++;
        if ({bus.a_cnt, bus.b_cnt, bus.attempts} !== 8'h00) begin
            failures++;
            $display("FAIL reset_score a=%0d b=%0d att=%0d required=0,0,0", bus.a_cnt, bus.b_cnt, bus.attempts);
        end
        checks++;
        if ({bus.oNumRdy, bus.res_vld, bus.err, bus.win, bus.lose} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_strobes rdy/res/err/win/lose=%b required=00000",
                     {bus.oNumRdy, bus.res_vld, bus.err, bus.win, bus.lose});
        end
        reset = 1'b0;
        tick();
        checks++;
        if (bus.state_o !== 3'd1) begin
            failures++;
            $display("FAIL reset_to_secret state_o=%0d required=1", bus.state_o);
        end
        model_att = 4'd0;
    endtask

    task automatic test_secret();
        int r0;
        r0 = rdy_seen;
        submit_secret(4'd1, 4'd2, 4'd3);
        checks++;
        if (rdy_seen - r0 != 1) begin
            failures++;
            $display("FAIL secret_rdy_count pulses=%0d required=1", rdy_seen - r0);
        end
    endtask

    task automatic test_guess();
        submit_guess(4'd3, 4'd2, 4'd4, 2'd1, 2'd1);
        submit_guess(4'd3, 4'd1, 4'd2, 2'd0, 2'd3);
    endtask

    task automatic test_invalid();
        int r0;
        r0 = rdy_seen;
        press_digits(4'd5, 4'd5, 4'd7);
        press_enter();
        checks++;
        if (bus.err !== 1'b1 || bus.state_o !== 3'd2 || bus.oNumRdy !== 1'b0) begin
            failures++;
            $display("FAIL dup_digits err=%b state_o=%0d rdy=%b required=1,2,0", bus.err, bus.state_o, bus.oNumRdy);
        end
        tick();
        press_enter();
        checks++;
        if (bus.err !== 1'b1) begin
            failures++;
            $display("FAIL buffer_kept err=%b required=1", bus.err);
        end
        press_clear();
        press_digit(4'd2);
        press_digit(4'd3);
        press_enter();
        checks++;
        if (bus.err !== 1'b1 || bus.state_o !== 3'd2) begin
            failures++;
            $display("FAIL two_digits err=%b state_o=%0d required=1,2", bus.err, bus.state_o);
        end
        checks++;
        if (rdy_seen - r0 != 0) begin
            failures++;
            $display("FAIL invalid_no_rdy pulses=%0d required=0", rdy_seen - r0);
        end
        press_clear();
        // 12 is not a digit and the fourth digit overflows the buffer.
        press_digit(4'd7);
        press_digit(4'd12);
        press_digit(4'd8);
        press_digit(4'd9);
        press_digit(4'd1);
        submit_buffer(12'h789, 2'd0, 2'd0);
        // clear beats enter in the same cycle
        press_digits(4'd4, 4'd5, 4'd6);
        bus.key_clear = 1'b1;
        bus.key_enter = 1'b1;
        tick();
        bus.key_clear = 1'b0;
        bus.key_enter = 1'b0;
        checks++;
        if (bus.oNumRdy !== 1'b0 || bus.err !== 1'b0 || bus.state_o !== 3'd2) begin
            failures++;
            $display("FAIL clear_over_enter rdy=%b err=%b state_o=%0d required=0,0,2", bus.oNumRdy, bus.err, bus.state_o);
        end
        tick();
        press_enter();
        checks++;
        if (bus.err !== 1'b1) begin
            failures++;
            $display("FAIL cleared_empty err=%b required=1", bus.err);
        end
        tick();
    endtask

    task automatic test_win();
        int r0;
        int e0;
        press_new_game();
        checks++;
        if (bus.state_o !== 3'd1 || bus.attempts !== 4'd0 || bus.a_cnt !== 2'd0 || bus.b_cnt !== 2'd0) begin
            failures++;
            $display("FAIL new_game_clear state_o=%0d att=%0d a=%0d b=%0d required=1,0,0,0",
                     bus.state_o, bus.attempts, bus.a_cnt, bus.b_cnt);
        end
        submit_secret(4'd4, 4'd5, 4'd6);
        submit_guess(4'd4, 4'd5, 4'd6, 2'd3, 2'd0);
        checks++;
        if (bus.win !== 1'b1 || bus.lose !== 1'b0) begin
            failures++;
            $display("FAIL win_level win=%b lose=%b required=1,0", bus.win, bus.lose);
        end
        r0 = rdy_seen;
        e0 = err_seen;
        press_digits(4'd1, 4'd2, 4'd3);
        press_enter();
        press_enter();
        tick();
        checks++;
        if (rdy_seen != r0 || err_seen != e0 || bus.state_o !== 3'd4) begin
            failures++;
            $display("FAIL win_ignores rdy=%0d err=%0d state_o=%0d required=0,0,4",
                     rdy_seen - r0, err_seen - e0, bus.state_o);
        end
        press_new_game();
        checks++;
        if (bus.state_o !== 3'd1 || bus.attempts !== 4'd0 || bus.win !== 1'b0) begin
            failures++;
            $display("FAIL win_restart state_o=%0d att=%0d win=%b required=1,0,0", bus.state_o, bus.attempts, bus.win);
        end
    endtask

    task automatic test_limit();
        int r0;
        submit_secret(4'd1, 4'd2, 4'd3);
        if (LIMIT_EN) begin
            for (int i = 0; i < 8; i++) submit_guess(4'd4, 4'd5, 4'd6, 2'd0, 2'd0);
            checks++;
            if (bus.lose !== 1'b1 || bus.state_o !== 3'd5 || bus.attempts !== 4'd8) begin
                failures++;
                $display("FAIL limit_lose lose=%b state_o=%0d att=%0d required=1,5,8", bus.lose, bus.state_o, bus.attempts);
            end
            r0 = rdy_seen;
            press_digits(4'd7, 4'd8, 4'd9);
            press_enter();
            tick();
            checks++;
            if (rdy_seen != r0 || bus.state_o !== 3'd5) begin
                failures++;
                $display("FAIL lose_sticky rdy=%0d state_o=%0d required=0,5", rdy_seen - r0, bus.state_o);
            end
        end else begin
            for (int i = 0; i < 16; i++) submit_guess(4'd4, 4'd5, 4'd6, 2'd0, 2'd0);
            checks++;
            if (bus.attempts !== 4'd15 || bus.lose !== 1'b0 || bus.state_o !== 3'd2) begin
                failures++;
                $display("FAIL unlimited att=%0d lose=%b state_o=%0d required=15,0,2", bus.attempts, bus.lose, bus.state_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        int s0;
        press_new_game();
        submit_secret(4'd1, 4'd2, 4'd3);
        // new_game while CHECK is occupied wins over scoring
        press_digits(4'd4, 4'd5, 4'd6);
        press_enter();
        s0 = res_seen;
        press_new_game();
        checks++;
        if (bus.state_o !== 3'd1 || bus.res_vld !== 1'b0 || bus.attempts !== 4'd0) begin
            failures++;
            $display("FAIL new_game_in_check state_o=%0d res_vld=%b att=%0d required=1,0,0",
                     bus.state_o, bus.res_vld, bus.attempts);
        end
        submit_secret(4'd7, 4'd8, 4'd9);
        // reset while CHECK is occupied suppresses the score
        press_digits(4'd9, 4'd8, 4'd7);
        press_enter();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.state_o !== 3'd0 || bus.res_vld !== 1'b0 || {bus.oNum1, bus.oNum2, bus.oNum3} !== 12'h000) begin
            failures++;
            $display("FAIL reset_in_check state_o=%0d res_vld=%b oNum=%h required=0,0,000",
                     bus.state_o, bus.res_vld, {bus.oNum1, bus.oNum2, bus.oNum3});
        end
        tick();
        checks++;
        if (bus.state_o !== 3'd1 || res_seen != s0) begin
            failures++;
            $display("FAIL reset_recover state_o=%0d res_pulses=%0d required=1,0", bus.state_o, res_seen - s0);
        end
        model_att = 4'd0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.key_val   = 4'd0;
        bus.key_vld   = 1'b0;
        bus.key_enter = 1'b0;
        bus.key_clear = 1'b0;
        bus.new_game  = 1'b0;
        model_att     = 4'd0;

        test_reset();
        test_secret();
        test_guess();
        test_invalid();
        test_win();
        test_limit();
        test_back_to_back();

        checks++;
        if (num_q.size() != 0 || res_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain num_left=%0d res_left=%0d required=0,0", num_q.size(), res_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
